// File: rtl/ir_pkg.sv
// NEC IR receiver shared types: FSM state encoding, microsecond timing
// windows and small decode helpers.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_MARK, BIT_SPACE, STOP_MARK
  } ir_state_e;

  // Microsecond acceptance windows (inclusive).
  localparam logic [13:0] LEAD_LOW_MIN  = 14'd8000;
  localparam logic [13:0] LEAD_LOW_MAX  = 14'd10000;
  localparam logic [13:0] LEAD_HIGH_MIN = 14'd4000;
  localparam logic [13:0] LEAD_HIGH_MAX = 14'd5000;
  localparam logic [13:0] RPT_HIGH_MIN  = 14'd2000;
  localparam logic [13:0] RPT_HIGH_MAX  = 14'd2500;
  localparam logic [13:0] MARK_MIN      = 14'd400;
  localparam logic [13:0] MARK_MAX      = 14'd700;
  localparam logic [13:0] ZERO_MIN      = 14'd400;
  localparam logic [13:0] ZERO_MAX      = 14'd700;
  localparam logic [13:0] ONE_MIN       = 14'd1400;
  localparam logic [13:0] ONE_MAX       = 14'd1900;
  localparam logic [13:0] TIMEOUT_US    = 14'd12000;
  localparam logic [13:0] US_MAX        = 14'd16383;

  function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Address and command bytes must each be followed by their inverse.
  function automatic logic frame_ok(input logic [31:0] f);
    return (f[31:24] == ~f[23:16]) && (f[15:8] == ~f[7:0]);
  endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Two-flop synchroniser plus glitch filter for the raw IR input. A new level
// is accepted only after FILTER_CYC consecutive samples disagree with the
// current one; rise/fall strobes are registered alongside the level.
module ir_input_filter #(
  parameter int FILTER_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_CYC + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  // Synchronise, then count disagreeing samples until the new level is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_CYC - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame receiver: filtered input, microsecond level timer, frame FSM
// with checksum. Define NEC_REPEAT_EN to re-pulse data_ready on repeat codes.
// Below 1 MHz each clock advances the timer by 1e6/CLK_HZ microseconds.
module nec_ir_receiver
  import ir_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        data_ready,
  output logic        frame_err
);

  localparam int          TICK_DIV = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int          US_INC   = (CLK_HZ >= 1_000_000) ? 1 : 1_000_000 / CLK_HZ;
  localparam int          PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [13:0] US_STEP  = 14'(US_INC);

  logic w_level, w_rise, w_fall, w_edge, w_rose, w_fell;

  ir_input_filter #(.FILTER_CYC(FILTER_CYC)) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (ir_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Edge direction is taken from the level that was just accepted.
  assign w_edge = w_rise | w_fall;
  assign w_rose = w_edge & w_level;
  assign w_fell = w_edge & ~w_level;

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic [13:0]      r_us;

  // Prescaler producing the microsecond tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PRE_W'(TICK_DIV - 1)) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_tick <= 1'b0;
    end
  end

  // Duration of the current level; cleared on each edge, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_us <= '0;
    else if (w_edge) r_us <= '0;
    else if (r_tick) r_us <= (r_us > (US_MAX - US_STEP)) ? US_MAX : r_us + US_STEP;
  end

  ir_state_e   r_state;
  logic [4:0]  r_bit;
  logic [31:0] r_shift;
  logic [31:0] r_ir_data;
  logic        r_data_ready;
  logic        r_frame_err;
`ifdef NEC_REPEAT_EN
  logic        r_rpt;
  logic        r_have_frame;
`endif

  // Frame decoder: edges are judged by the duration of the level they end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit        <= '0;
      r_shift      <= '0;
      r_ir_data    <= '0;
      r_data_ready <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef NEC_REPEAT_EN
      r_rpt        <= 1'b0;
      r_have_frame <= 1'b0;
`endif
    end else begin
      r_data_ready <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state != IDLE && !w_edge && r_us > TIMEOUT_US) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (w_fell) r_state <= LEAD_LOW;
          LEAD_LOW: if (w_rose) begin
            if (in_win(r_us, LEAD_LOW_MIN, LEAD_LOW_MAX)) r_state <= LEAD_HIGH;
            else begin r_state <= IDLE; r_frame_err <= 1'b1; end
          end
          LEAD_HIGH: if (w_fell) begin
            if (in_win(r_us, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
              r_state <= BIT_MARK;
              r_bit   <= '0;
`ifdef NEC_REPEAT_EN
              r_rpt   <= 1'b0;
            end else if (in_win(r_us, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
              r_state <= STOP_MARK;
              r_rpt   <= 1'b1;
`else
            end else if (in_win(r_us, RPT_HIGH_MIN, RPT_HIGH_MAX)) begin
              r_state <= IDLE;
`endif
            end else begin
              r_state     <= IDLE;
              r_frame_err <= 1'b1;
            end
          end
          BIT_MARK: if (w_rose) begin
            if (in_win(r_us, MARK_MIN, MARK_MAX)) r_state <= BIT_SPACE;
            else begin r_state <= IDLE; r_frame_err <= 1'b1; end
          end
          BIT_SPACE: if (w_fell) begin
            if (in_win(r_us, ZERO_MIN, ZERO_MAX) || in_win(r_us, ONE_MIN, ONE_MAX)) begin
              r_shift <= {in_win(r_us, ONE_MIN, ONE_MAX), r_shift[31:1]};
              r_bit   <= r_bit + 1'b1;
              r_state <= (r_bit == 5'd31) ? STOP_MARK : BIT_MARK;
            end else begin
              r_state     <= IDLE;
              r_frame_err <= 1'b1;
            end
          end
          STOP_MARK: if (w_rose) begin
            r_state <= IDLE;
            if (!in_win(r_us, MARK_MIN, MARK_MAX)) begin
              r_frame_err <= 1'b1;
`ifdef NEC_REPEAT_EN
            end else if (r_rpt) begin
              r_data_ready <= r_have_frame;
`endif
            end else if (frame_ok(r_shift)) begin
              r_ir_data    <= r_shift;
              r_data_ready <= 1'b1;
`ifdef NEC_REPEAT_EN
              r_have_frame <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ir_data    = r_ir_data;
  assign data_ready = r_data_ready;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed bench for nec_ir_receiver. Runs at CLK_HZ = 100 kHz so one clock
// is 10 us and whole NEC frames fit in a few thousand cycles.
module tb_nec_ir_receiver;

  localparam int FILT = 4;
`ifdef NEC_REPEAT_EN
  localparam int RPT_EXP = 1;
`else
  localparam int RPT_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] ir_data;
  logic        data_ready;
  logic        frame_err;

  nec_ir_receiver #(.CLK_HZ(100_000), .FILTER_CYC(FILT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_in      (ir_in),
    .ir_data    (ir_data),
    .data_ready (data_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, n_dr = 0, n_fe = 0, n_both = 0, fe_cyc = 0;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (data_ready) n_dr++;
    if (frame_err) begin n_fe++; fe_cyc = cyc; end
    if (data_ready && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic lvl(input logic v, input int us);
    ir_in = v;
    repeat (us / 10) @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // Leader, nbits data bits LSB first, and the stop mark when complete.
  task automatic send(input logic [31:0] w, input int nbits);
    lvl(1'b0, 9000);
    lvl(1'b1, 4500);
    for (int i = 0; i < nbits; i++) begin
      lvl(1'b0, 560);
      lvl(1'b1, w[i] ? 1690 : 560);
    end
    if (nbits == 32) begin
      lvl(1'b0, 560);
      ir_in = 1'b1;
    end
  endtask

  initial begin
    int d0, e0, lat, c0;
    logic [31:0] w;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_ir_data", ir_data, 32'h0);
    chk("rst_data_ready", {31'b0, data_ready}, 32'h0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1- and 3-cycle glitches are filtered out
    d0 = n_dr; e0 = n_fe;
    lvl(1'b0, 10);  lvl(1'b1, 300);
    lvl(1'b0, 30);  lvl(1'b1, 300);
    chk("glitch_dr", n_dr - d0, 0);
    chk("glitch_fe", n_fe - e0, 0);

    // 4-cycle low passes the filter: a far too short leader
    d0 = n_dr; e0 = n_fe;
    lvl(1'b0, 40);  lvl(1'b1, 300);
    chk("short_lead_fe", n_fe - e0, 1);
    chk("short_lead_dr", n_dr - d0, 0);

    // Address 0x00, command 0x0C, ideal timing, with stop latency
    d0 = n_dr; e0 = n_fe; lat = 0;
    send(mk(8'h00, 8'h0C), 32);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (data_ready && lat == 0) lat = i;
    end
    chk("f0C_dr", n_dr - d0, 1);
    chk("f0C_fe", n_fe - e0, 0);
    chk("f0C_data", ir_data, 32'hF30CFF00);
    chk("f0C_latency_ok", {31'b0, (lat >= 1 && lat <= FILT + 4)}, 32'h1);

    // Command 0x1B with bit 27 flipped: checksum fails, data holds
    d0 = n_dr; e0 = n_fe;
    w = mk(8'h00, 8'h1B) ^ 32'h0800_0000;
    send(w, 32);
    lvl(1'b1, 500);
    chk("bad_fe", n_fe - e0, 1);
    chk("bad_dr", n_dr - d0, 0);
    chk("bad_data_hold", ir_data, 32'hF30CFF00);

    // Valid leader, then low for 15 ms: timeout near 12000 us
    d0 = n_dr; e0 = n_fe;
    lvl(1'b0, 9000);
    lvl(1'b1, 4500);
    c0 = cyc;
    lvl(1'b0, 15000);
    lvl(1'b1, 500);
    chk("tmo_fe", n_fe - e0, 1);
    chk("tmo_dr", n_dr - d0, 0);
    chk("tmo_when_ok", {31'b0, ((fe_cyc - c0) >= 1195 && (fe_cyc - c0) <= 1220)}, 32'h1);

    // Frame 0x14 followed by a repeat code
    d0 = n_dr; e0 = n_fe;
    send(mk(8'h00, 8'h14), 32);
    lvl(1'b1, 500);
    chk("f14_dr", n_dr - d0, 1);
    chk("f14_data", ir_data, 32'hEB14FF00);
    d0 = n_dr;
    lvl(1'b0, 9000);
    lvl(1'b1, 2250);
    lvl(1'b0, 560);
    lvl(1'b1, 500);
    chk("rpt_dr", n_dr - d0, RPT_EXP);
    chk("rpt_fe", n_fe - e0, 0);
    chk("rpt_data", ir_data, 32'hEB14FF00);

    // Reset at bit 16, then a clean 0x18 frame
    d0 = n_dr; e0 = n_fe;
    send(mk(8'h00, 8'h18), 16);
    ir_in = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_data", ir_data, 32'h0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_dr", n_dr - d0, 0);
    chk("midrst_fe", n_fe - e0, 0);
    send(mk(8'h00, 8'h18), 32);
    lvl(1'b1, 500);
    chk("f18_dr", n_dr - d0, 1);
    chk("f18_data", ir_data, 32'hE718FF00);

    chk("never_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nec_ir_receiver.md
NEC_IR_RECEIVER -- requirements
Module: nec_ir_receiver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FILTER_CYC, default 4, number of stable cycles required to accept an input level change.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ir_in  input  1  raw demodulated IR receiver output, asynchronous; idle high, mark = low.
REQ-006 SHALL have port ir_data  output  32  last valid frame: [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
REQ-007 SHALL have port data_ready  output  1  one-cycle pulse when ir_data holds a new or repeated valid frame.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on an aborted or checksum-failed frame.

Function
REQ-009 SHALL pass ir_in through a 2-flop synchroniser, then a glitch filter that accepts a new level only after FILTER_CYC consecutive equal samples.
REQ-010 SHALL generate a 1 us tick from a prescaler of CLK_HZ/1_000_000 cycles.
REQ-011 SHALL time each filtered level in a 14-bit microsecond counter that clears on every accepted edge and saturates at 16383.
REQ-012 SHALL implement the states IDLE, LEAD_LOW, LEAD_HIGH, BIT_MARK, BIT_SPACE and STOP_MARK.
REQ-013 IDLE -> LEAD_LOW on a falling edge.
REQ-014 LEAD_LOW -> LEAD_HIGH on a rising edge if the low duration is 8000-10000 us, else -> IDLE with frame_err.
REQ-015 LEAD_HIGH -> BIT_MARK on a falling edge if the high duration is 4000-5000 us, with bit index cleared.
REQ-016 BIT_MARK -> BIT_SPACE on a rising edge if the mark duration is 400-700 us, else -> IDLE with frame_err.
REQ-017 BIT_SPACE on a falling edge SHALL decode 400-700 us as 0 and 1400-1900 us as 1, and shift the bit into a 32-bit register LSB-first.
REQ-018 BIT_SPACE SHALL go to BIT_MARK after bits 0-30 and to STOP_MARK after bit 31; any other space duration -> IDLE with frame_err.
REQ-019 STOP_MARK -> IDLE on a rising edge with a 400-700 us mark, then the checksum is evaluated.
REQ-020 The checksum SHALL pass only when shift[31:24] == ~shift[23:16] and shift[15:8] == ~shift[7:0].
REQ-021 On checksum pass, ir_data SHALL load the shift register and data_ready SHALL pulse in the same cycle; on fail, frame_err SHALL pulse and ir_data SHALL hold.
REQ-022 data_ready SHALL assert no later than FILTER_CYC+4 clk after the raw ir_in rising edge that ends the stop mark.
REQ-023 In any non-IDLE state, a level lasting longer than 12000 us SHALL force IDLE with frame_err (timeout).
REQ-024 ir_data SHALL change only on a valid frame and SHALL otherwise hold indefinitely.
REQ-025 data_ready and frame_err SHALL never assert in the same cycle.
REQ-026 A falling edge arriving in IDLE during a frame_err cycle SHALL still start LEAD_LOW.

Reset
REQ-027 On rst_n low, the block SHALL go to state IDLE with ir_data = 32'h0, data_ready = 0 and frame_err = 0.
REQ-028 On rst_n low, the synchroniser and filter SHALL be set to 1 and the counters and shift register cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output pulse.

Configuration
REQ-030 With macro NEC_REPEAT_EN defined, LEAD_HIGH with a 2000-2500 us high followed by a valid 400-700 us stop mark SHALL re-pulse data_ready with ir_data unchanged.
REQ-031 The repeat pulse of REQ-030 SHALL be given only if a valid frame was received since reset.
REQ-032 Without NEC_REPEAT_EN, a 2000-2500 us leader high SHALL return to IDLE with no data_ready and no frame_err.

Structure
REQ-033 Package ir_pkg SHALL hold the state enum and all microsecond timing window constants (min/max for leader, repeat, mark, 0-space, 1-space, timeout).
REQ-034 Sub-module ir_input_filter SHALL contain the synchroniser and glitch filter and output the filtered level plus one-cycle rise and fall strobes.

Verification
REQ-035 Address 0x00, command 0x0C, ideal NEC timing -> one data_ready pulse and ir_data = 32'hF30CFF00.
REQ-036 Command 0x1B with bit 27 flipped -> frame_err pulse, no data_ready, ir_data holds its previous value.
REQ-037 Valid leader, then ir_in held low for 15 ms -> frame_err pulse at 12000 us and return to IDLE.
REQ-038 1-cycle and 3-cycle low glitches on ir_in while idle -> no state change and no pulses.
REQ-039 Valid 0x14 frame then a repeat frame -> two data_ready pulses with NEC_REPEAT_EN, one without; ir_data = 32'hEB14FF00 throughout.
REQ-040 rst_n asserted at bit 16 of a frame, released, then a full 0x18 frame sent -> only the 0x18 frame is reported.
